// File: rtl/shift_deserializer_shift_core.sv
// Enabled serial shift register with bit counter; flags the WIDTH-th qualified bit.
// Latency: done/next_word are combinational on the completing bit; state updates on the edge.
// Backpressure: none here; the top-level holding register absorbs consumer stalls.
module shift_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             data,
    input  logic             data_en,
    input  logic             clear,
    output logic [CW-1:0]    bit_count,
    output logic             done,
    output logic [WIDTH-1:0] next_word
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             last;

    always_comb begin
        shifted = '0;
        if (MSB_FIRST) begin
            shifted = {sreg[WIDTH-2:0], data};
        end else begin
            shifted = {data, sreg[WIDTH-1:1]};
        end
    end

    assign last      = (bit_count == CW'(WIDTH - 1));
    // clear beats data_en, so a bit arriving with clear never completes a word
    assign done      = data_en & ~clear & last;
    assign next_word = shifted;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (data_en) begin
            if (last) begin
                sreg      <= '0;
                bit_count <= '0;
            end else begin
                sreg      <= shifted;
                bit_count <= bit_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with a one-word holding register on a valid/ready output.
// Latency: word visible one edge after its WIDTH-th bit; shifting continues while the consumer stalls.
// Backpressure: a word completing while the held word is unconsumed is dropped and sets sticky overrun.
module shift_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             data,
    input  logic             data_en,
    input  logic             clear,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);

    logic             done;
    logic [WIDTH-1:0] next_word;
    logic             consume;

    shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .data_en   (data_en),
        .clear     (clear),
        .bit_count (bit_count),
        .done      (done),
        .next_word (next_word)
    );

    assign consume = word_valid & word_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done) begin
                // a consume on the same edge frees the slot, so the new word loads without a bubble
                if (!word_valid || consume) begin
                    word_out   <= next_word;
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                word_valid <= 1'b0;
            end
            if (clear) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; a monitor checks each consumed word.
module tb_shift_deserializer;

    logic       clock;
    logic       reset_n;
    logic       data;
    logic       data_en;
    logic       clear;
    logic       word_ready;
    logic [7:0] word_m, word_l;
    logic       valid_m, valid_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ovr_m, ovr_l;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data       (data),
        .data_en    (data_en),
        .clear      (clear),
        .word_out   (word_m),
        .word_valid (valid_m),
        .word_ready (word_ready),
        .bit_count  (cnt_m),
        .overrun    (ovr_m)
    );

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock      (clock),
        .reset_n    (reset_n),
        .data       (data),
        .data_en    (data_en),
        .clear      (clear),
        .word_out   (word_l),
        .word_valid (valid_l),
        .word_ready (word_ready),
        .bit_count  (cnt_l),
        .overrun    (ovr_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every consume edge must present the next scoreboard word.
    always @(negedge clock) begin
        if (reset_n && valid_m && word_ready) begin
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL msb_unexpected_word: got 0x%0h expected none", word_m);
            end else begin
                check("msb_word", {24'd0, word_m}, {24'd0, q_m.pop_front()});
            end
        end
        if (reset_n && valid_l && word_ready) begin
            if (q_l.size() == 0) begin
                total++; bad++;
                $display("FAIL lsb_unexpected_word: got 0x%0h expected none", word_l);
            end else begin
                check("lsb_word", {24'd0, word_l}, {24'd0, q_l.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        data    = b;
        data_en = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        data_en = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        reset_n = 1'b0; data = 1'b1; data_en = 1'b1; clear = 1'b0; word_ready = 1'b0;
        #1;
        tick(); tick();
        check("rst_word", {24'd0, word_m}, 32'h00);
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_count", {29'd0, cnt_m}, 32'd0);
        check("rst_overrun", {31'd0, ovr_m}, 32'd0);

        reset_n = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        data_en = 1'b0;
        check("count_3", {29'd0, cnt_m}, 32'd3);
        reset_n = 1'b0;
        tick();
        check("midword_rst_count", {29'd0, cnt_m}, 32'd0);
        reset_n = 1'b1;

        // Basic word: 1,0,1,1,0,0,1,0 -> 0xB2 MSB-first, 0x4D LSB-first
        word_ready = 1'b1;
        q_m.push_back(8'hB2); q_l.push_back(8'h4D);
        send_byte(8'hB2);
        check("basic_valid", {31'd0, valid_m}, 32'd1);
        check("basic_word", {24'd0, word_m}, 32'hB2);
        check("basic_word_lsb", {24'd0, word_l}, 32'h4D);
        tick();
        check("basic_valid_one_cycle", {31'd0, valid_m}, 32'd0);

        // Gapped input with 3 idle cycles per bit
        q_m.push_back(8'hB2); q_l.push_back(8'h4D);
        pat = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            check("gap_count_before", {29'd0, cnt_m}, i);
            send_bit(pat[7-i]);
            data_en = 1'b0;
            if (i == 7) begin
                check("gap_valid", {31'd0, valid_m}, 32'd1);
                check("gap_word", {24'd0, word_m}, 32'hB2);
            end
            tick(); tick(); tick();
            check("gap_count_hold", {29'd0, cnt_m}, (i + 1) % 8);
        end

        // Stall: 0xA5 held, 0x3C dropped (both are bit-palindromes, so LSB instance matches)
        word_ready = 1'b0;
        q_m.push_back(8'hA5); q_l.push_back(8'hA5);
        send_byte(8'hA5);
        check("stall_word", {24'd0, word_m}, 32'hA5);
        check("stall_no_overrun", {31'd0, ovr_m}, 32'd0);
        send_byte(8'h3C);
        check("stall_word_kept", {24'd0, word_m}, 32'hA5);
        check("stall_valid_kept", {31'd0, valid_m}, 32'd1);
        check("stall_overrun", {31'd0, ovr_m}, 32'd1);
        check("stall_overrun_lsb", {31'd0, ovr_l}, 32'd1);
        word_ready = 1'b1;
        tick();
        check("stall_consumed", {31'd0, valid_m}, 32'd0);
        check("overrun_sticky", {31'd0, ovr_m}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_overrun", {31'd0, ovr_m}, 32'd0);
        check("clear_valid", {31'd0, valid_m}, 32'd0);

        // Completion and consume on the same edge
        word_ready = 1'b0;
        q_m.push_back(8'h11); q_l.push_back(8'h88);
        send_byte(8'h11);
        pat = 8'h22;
        for (int i = 7; i >= 1; i--) send_bit(pat[i]);
        word_ready = 1'b1;
        q_m.push_back(8'h22); q_l.push_back(8'h44);
        send_bit(pat[0]);
        data_en = 1'b0;
        check("b2b_word", {24'd0, word_m}, 32'h22);
        check("b2b_word_lsb", {24'd0, word_l}, 32'h44);
        check("b2b_valid", {31'd0, valid_m}, 32'd1);
        check("b2b_overrun", {31'd0, ovr_m}, 32'd0);
        tick();
        check("b2b_drained", {31'd0, valid_m}, 32'd0);

        // Clear mid-word with a held word present
        word_ready = 1'b0;
        q_m.push_back(8'h5A); q_l.push_back(8'h5A);
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("pre_clear_count", {29'd0, cnt_m}, 32'd5);
        clear = 1'b1; data = 1'b1; data_en = 1'b1;
        tick();
        clear = 1'b0; data_en = 1'b0;
        check("clear_count", {29'd0, cnt_m}, 32'd0);
        check("clear_held_word", {24'd0, word_m}, 32'h5A);
        check("clear_held_valid", {31'd0, valid_m}, 32'd1);
        word_ready = 1'b1;
        tick();
        q_m.push_back(8'h96); q_l.push_back(8'h69);
        send_byte(8'h96);
        check("post_clear_word", {24'd0, word_m}, 32'h96);
        check("post_clear_word_lsb", {24'd0, word_l}, 32'h69);
        tick(); tick();

        check("scoreboard_msb_empty", q_m.size(), 32'd0);
        check("scoreboard_lsb_empty", q_l.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-to-parallel stage that sits directly downstream of the single-bit D flip-flop. It consumes the registered serial bit stream (the flop's q output) and accumulates WIDTH qualified bits into a shift register. On completion it transfers the word to a holding register, which is presented to the consumer over a valid/ready handshake. Because of the holding register, shifting of the next word continues while the consumer stalls.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset; sampled on the rising edge of clock.
- data, input, 1: serial bit, driven from the upstream flop's q.
- data_en, input, 1: qualifies data; a bit is shifted in only on edges where data_en=1.
- clear, input, 1: synchronous abort of the partial word in progress.
- word_out, output, WIDTH: completed word in the holding register.
- word_valid, output, 1: word_out holds an unconsumed word.
- word_ready, input, 1: consumer accepts word_out on an edge where word_valid=1.
- bit_count, output, CW = ceil(log2(WIDTH)): number of bits accumulated in the partial word, 0..WIDTH-1.
- overrun, output, 1: sticky flag; a completed word was dropped.

Behaviour:
- Reset (reset_n=0 at an edge): shift register=0, bit_count=0, word_out=0, word_valid=0, overrun=0. Reset overrides every other input. Reset mid-word discards the partial word and any held word.
- Shift on data_en=1 (with clear=0):
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], data}.
  - MSB_FIRST=0: sreg <= {data, sreg[WIDTH-1:1]}.
  - bit_count increments by 1.
- Completion: data_en=1 while bit_count==WIDTH-1.
  - The completed word (including the current bit) is the candidate for the holding register.
  - bit_count wraps to 0 and sreg clears to 0 on the same edge.
  - Latency: the word is visible on word_out one edge after the WIDTH-th bit is sampled.
- Holding register / handshake, evaluated per edge (consume = word_valid & word_ready):
  - completion, word_valid=0: load word_out, word_valid<=1.
  - completion & consume: load the new word_out, word_valid stays 1 (no bubble).
  - completion, word_valid=1, no consume: keep the old word_out, drop the new word, overrun<=1.
  - no completion & consume: word_valid<=0; word_out holds its last value.
- Stability: word_out and word_valid never change while word_valid=1 and word_ready=0.
- clear=1 (reset_n=1):
  - bit_count<=0, sreg<=0, overrun<=0.
  - A data bit arriving on the same edge is discarded (clear wins over data_en).
  - The holding register and word_valid are unaffected; a consume on the same edge still completes.
- data_en=0: sreg and bit_count hold. Gaps of any length between bits are legal.
- overrun stays 1 until clear or reset.

Decomposition:
- No shared package required. CW is a localparam derived from WIDTH inside the block.
- One natural sub-module, shift_core: WIDTH-bit enabled shift register plus bit counter. It outputs the completion strobe and the next-word value.
- The top level owns the holding register, the handshake and overrun.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with data_en=1, data=1 -> word_out=0x00, word_valid=0, bit_count=0, overrun=0. Drive reset_n=0 mid-word after 3 bits -> bit_count=0 on the next edge.
- Basic word, WIDTH=8, MSB_FIRST=1: bits 1,0,1,1,0,0,1,0 on consecutive edges, word_ready=1 -> word_out=0xB2, word_valid=1 for exactly one cycle, one edge after the 8th bit. Same bits with MSB_FIRST=0 -> 0x4D.
- Gapped input: same 8 bits with data_en=0 for 3 cycles between each bit -> word_out=0xB2; bit_count steps 0..7 and holds during gaps.
- Back-to-back with stall: send 0xA5 with word_ready=0, then 0x3C -> word_out stays 0xA5, overrun=1 after the 0x3C completes. Raise word_ready, then clear -> word_valid=0, overrun=0.
- Simultaneous completion and consume: word_valid=1 (0x11), word_ready=1 on the edge 0x22 completes -> word_out=0x22, word_valid stays 1, overrun=0.
- Clear mid-word: 5 bits in, then clear=1 with data_en=1 -> bit_count=0, the bit is discarded, the held word is unchanged; the next 8 bits form a correct word.
